// File: rtl/sel_encode_seq.sv
// Register select/encode unit: local IR, Ra/Rb/Rc field decode to one-hot
// register enables, C-immediate sign extension and a single-pulse operand sequencer.
module sel_encode_seq #(
    parameter int DATA_W = 32,
    parameter int NREG   = 16,
    parameter int RA_LSB = 23,
    parameter int RB_LSB = 19,
    parameter int RC_LSB = 15,
    parameter int IMM_W  = 19
) (
    input  logic                      clk,
    input  logic                      clr,
    input  logic                      ir_ld,
    input  logic [DATA_W-1:0]         ir_in,
    input  logic                      gra,
    input  logic                      grb,
    input  logic                      grc,
    input  logic                      rin,
    input  logic                      rout,
    input  logic                      baout,
    input  logic                      seq_start,
    input  logic [2:0]                seq_mask,
    output logic [NREG-1:0]           r_in,
    output logic [NREG-1:0]           r_out,
    output logic [$clog2(NREG)-1:0]   sel_idx,
    output logic                      r0_zero,
    output logic [DATA_W-1:0]         c_sign_extend,
    output logic                      seq_busy,
    output logic [1:0]                seq_field,
    output logic                      seq_done
);

    localparam int RSEL_W = $clog2(NREG);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FA,
        S_FB,
        S_FC,
        S_DONE
    } state_t;

    state_t              state_q, state_d;
    logic [2:0]          mask_q, mask_d;
    logic [DATA_W-1:0]   ir_q, ir_d;

    logic [RSEL_W-1:0]   ra, rb, rc, idx_man, idx;
    logic [NREG-1:0]     dec;
    logic                any_gr;

    // ------------------------------------------------------------------
    // State, latched mask and local IR
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_q <= S_IDLE;
            mask_q  <= '0;
            ir_q    <= '0;
        end else begin
            state_q <= state_d;
            mask_q  <= mask_d;
            ir_q    <= ir_d;
        end
    end

    // The IR is frozen while sequencing so every field comes from one instruction
    always_comb begin
        ir_d = ir_q;
        if (ir_ld && (state_q == S_IDLE))
            ir_d = ir_in;
    end

    // ------------------------------------------------------------------
    // Sequencer next-state
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        mask_d  = mask_q;
        unique case (state_q)
            S_IDLE: begin
                if (seq_start) begin
                    mask_d = seq_mask;
                    if (seq_mask[0])      state_d = S_FA;
                    else if (seq_mask[1]) state_d = S_FB;
                    else if (seq_mask[2]) state_d = S_FC;
                    else                  state_d = S_DONE;
                end
            end
            S_FA: begin
                if (mask_q[1])      state_d = S_FB;
                else if (mask_q[2]) state_d = S_FC;
                else                state_d = S_DONE;
            end
            S_FB: begin
                if (mask_q[2]) state_d = S_FC;
                else           state_d = S_DONE;
            end
            S_FC:    state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Field extraction and decode
    // ------------------------------------------------------------------
    assign ra = ir_q[RA_LSB +: RSEL_W];
    assign rb = ir_q[RB_LSB +: RSEL_W];
    assign rc = ir_q[RC_LSB +: RSEL_W];

    // Multiple manual selects OR together rather than prioritise
    assign idx_man = (ra & {RSEL_W{gra}}) | (rb & {RSEL_W{grb}}) | (rc & {RSEL_W{grc}});
    assign any_gr  = gra | grb | grc;

    always_comb begin
        idx = idx_man;
        unique case (state_q)
            S_FA:    idx = ra;
            S_FB:    idx = rb;
            S_FC:    idx = rc;
            default: idx = idx_man;
        endcase
    end

    assign dec = NREG'(1) << idx;

    always_comb begin
        r_in      = '0;
        r_out     = '0;
        r0_zero   = 1'b0;
        seq_field = 2'd0;
        seq_done  = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                r_in    = dec & {NREG{rin}};
                r_out   = dec & {NREG{rout | baout}};
                r0_zero = baout & (idx == '0) & any_gr;
            end
            S_FA: begin
                r_out     = dec;
                seq_field = 2'd1;
            end
            S_FB: begin
                r_out     = dec;
                seq_field = 2'd2;
            end
            S_FC: begin
                r_out     = dec;
                seq_field = 2'd3;
            end
            S_DONE:  seq_done = 1'b1;
            default: ;
        endcase
    end

    assign sel_idx       = idx;
    assign seq_busy      = (state_q != S_IDLE);
    assign c_sign_extend = {{(DATA_W-IMM_W){ir_q[IMM_W-1]}}, ir_q[IMM_W-1:0]};

    // Opcode bits and mask[0] have no consumer once latched
    logic unused_bits;
    assign unused_bits = ^{ir_q, mask_q[0]};

endmodule

// File: tb/tb_sel_encode_seq.sv
// Directed bench for sel_encode_seq: manual decode, sign extension, sequencer
// masks, IR freeze, reset abort, plus an NREG=8 instance for 8-bit decoding.
module tb_sel_encode_seq;

    logic        clk = 1'b0;
    logic        clr;
    logic        ir_ld;
    logic [31:0] ir_in;
    logic        gra, grb, grc, rin, rout, baout, seq_start;
    logic [2:0]  seq_mask;

    logic [15:0] r_in, r_out;
    logic [3:0]  sel_idx;
    logic        r0_zero, seq_busy, seq_done;
    logic [31:0] c_sign_extend;
    logic [1:0]  seq_field;

    logic [7:0]  r_in8, r_out8;
    logic [2:0]  sel_idx8;
    logic        r0_zero8, seq_busy8, seq_done8;
    logic [31:0] c_sign_extend8;
    logic [1:0]  seq_field8;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    sel_encode_seq dut (
        .clk(clk), .clr(clr), .ir_ld(ir_ld), .ir_in(ir_in),
        .gra(gra), .grb(grb), .grc(grc), .rin(rin), .rout(rout), .baout(baout),
        .seq_start(seq_start), .seq_mask(seq_mask),
        .r_in(r_in), .r_out(r_out), .sel_idx(sel_idx), .r0_zero(r0_zero),
        .c_sign_extend(c_sign_extend), .seq_busy(seq_busy),
        .seq_field(seq_field), .seq_done(seq_done)
    );

    sel_encode_seq #(.NREG(8), .RA_LSB(24)) dut8 (
        .clk(clk), .clr(clr), .ir_ld(ir_ld), .ir_in(ir_in),
        .gra(gra), .grb(grb), .grc(grc), .rin(rin), .rout(rout), .baout(baout),
        .seq_start(seq_start), .seq_mask(seq_mask),
        .r_in(r_in8), .r_out(r_out8), .sel_idx(sel_idx8), .r0_zero(r0_zero8),
        .c_sign_extend(c_sign_extend8), .seq_busy(seq_busy8),
        .seq_field(seq_field8), .seq_done(seq_done8)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; checks follow 1 unit later
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        gra = 0; grb = 0; grc = 0; rin = 0; rout = 0; baout = 0;
        seq_start = 0; seq_mask = 3'b000; ir_ld = 0;
    endtask

    initial begin
        clr = 1'b0; ir_in = '0;
        idle_in();
        gra = 1; baout = 1;
        #3;
        chk("rst_busy",  {31'd0, seq_busy}, 32'd0);
        chk("rst_done",  {31'd0, seq_done}, 32'd0);
        chk("rst_field", {30'd0, seq_field}, 32'd0);
        chk("rst_cse",   c_sign_extend, 32'h0);
        chk("rst_rout",  {16'd0, r_out}, 32'h0001);
        chk("rst_r0z",   {31'd0, r0_zero}, 32'd1);
        tick();
        clr = 1'b1;

        // Manual decode: Ra=6 Rb=3 Rc=4
        idle_in();
        ir_in = 32'h0B1A0000; ir_ld = 1;
        tick();
        ir_ld = 0; gra = 1; rout = 1;
        #1;
        chk("man_ra_rout", {16'd0, r_out}, 32'h0040);
        chk("man_ra_rin",  {16'd0, r_in}, 32'h0);
        chk("man_ra_idx",  {28'd0, sel_idx}, 32'd6);
        chk("man_ra_r0z",  {31'd0, r0_zero}, 32'd0);
        chk("n8_ra_rout",  {24'd0, r_out8}, 32'h08);
        chk("cse_pos",     c_sign_extend, 32'h00020000);
        gra = 0; rout = 0; grb = 1; rin = 1;
        #1;
        chk("man_rb_rin",  {16'd0, r_in}, 32'h0008);
        chk("man_rb_rout", {16'd0, r_out}, 32'h0);
        gra = 1;
        #1;
        chk("man_or_rin",  {16'd0, r_in}, 32'h0080);

        // Base-address read of R0, negative immediate
        idle_in();
        ir_in = 32'h00040001; ir_ld = 1;
        tick();
        ir_ld = 0; gra = 1; baout = 1;
        #1;
        chk("ba_r0_rout", {16'd0, r_out}, 32'h0001);
        chk("ba_r0_r0z",  {31'd0, r0_zero}, 32'd1);
        chk("cse_neg",    c_sign_extend, 32'hFFFC0001);

        // Ra=5, largest positive immediate
        idle_in();
        ir_in = 32'h0283FFFF; ir_ld = 1;
        tick();
        ir_ld = 0; gra = 1; baout = 1;
        #1;
        chk("ba_r5_r0z",  {31'd0, r0_zero}, 32'd0);
        chk("ba_r5_rout", {16'd0, r_out}, 32'h0020);
        chk("cse_max",    c_sign_extend, 32'h0003FFFF);

        // Full sequence, loaded on the same edge as start, manual rin ignored
        idle_in();
        ir_in = 32'h0B1A0000; ir_ld = 1; seq_start = 1; seq_mask = 3'b111;
        tick();
        seq_start = 0; ir_in = 32'h0; gra = 1; rin = 1;
        #1;
        chk("s7_fa_rout",  {16'd0, r_out}, 32'h0040);
        chk("s7_fa_field", {30'd0, seq_field}, 32'd1);
        chk("s7_fa_rin",   {16'd0, r_in}, 32'h0);
        chk("s7_fa_busy",  {31'd0, seq_busy}, 32'd1);
        chk("n8_fa_rout",  {24'd0, r_out8}, 32'h08);
        tick();
        chk("s7_fb_rout",  {16'd0, r_out}, 32'h0008);
        chk("s7_fb_field", {30'd0, seq_field}, 32'd2);
        chk("s7_fb_rin",   {16'd0, r_in}, 32'h0);
        tick();
        chk("s7_fc_rout",  {16'd0, r_out}, 32'h0010);
        chk("s7_fc_field", {30'd0, seq_field}, 32'd3);
        chk("n8_fc_rout",  {24'd0, r_out8}, 32'h10);
        tick();
        chk("s7_dn_done",  {31'd0, seq_done}, 32'd1);
        chk("s7_dn_rout",  {16'd0, r_out}, 32'h0);
        chk("s7_dn_field", {30'd0, seq_field}, 32'd0);
        chk("s7_dn_busy",  {31'd0, seq_busy}, 32'd1);
        tick();
        ir_ld = 0;
        #1;
        chk("s7_end_busy", {31'd0, seq_busy}, 32'd0);
        chk("s7_end_done", {31'd0, seq_done}, 32'd0);
        chk("ir_frozen",   {28'd0, sel_idx}, 32'd6);
        chk("ir_frz_cse",  c_sign_extend, 32'h00020000);
        chk("idle_rin",    {16'd0, r_in}, 32'h0040);

        // Sparse mask: Ra then Rc
        idle_in();
        seq_start = 1; seq_mask = 3'b101;
        tick();
        seq_start = 0; seq_mask = 3'b111;
        #1;
        chk("s5_fa_rout",  {16'd0, r_out}, 32'h0040);
        tick();
        chk("s5_fc_field", {30'd0, seq_field}, 32'd3);
        chk("s5_fc_rout",  {16'd0, r_out}, 32'h0010);
        tick();
        chk("s5_dn_done",  {31'd0, seq_done}, 32'd1);
        tick();
        chk("s5_idle",     {31'd0, seq_busy}, 32'd0);

        // Mask latched at start: later mask changes must not add fields
        seq_start = 1; seq_mask = 3'b010;
        tick();
        seq_start = 0; seq_mask = 3'b111;
        #1;
        chk("s2_fb_field", {30'd0, seq_field}, 32'd2);
        tick();
        chk("s2_dn_done",  {31'd0, seq_done}, 32'd1);
        tick();

        // Empty mask, start held high: DONE, IDLE, DONE again
        seq_start = 1; seq_mask = 3'b000; rout = 1; gra = 1;
        tick();
        chk("s0_done",  {31'd0, seq_done}, 32'd1);
        chk("s0_rout",  {16'd0, r_out}, 32'h0);
        tick();
        chk("s0_idle",  {31'd0, seq_busy}, 32'd0);
        tick();
        chk("s0_again", {31'd0, seq_done}, 32'd1);
        seq_start = 0;
        tick();
        chk("s0_end",   {31'd0, seq_busy}, 32'd0);

        // Reset during FB aborts without a done pulse
        idle_in();
        seq_start = 1; seq_mask = 3'b111;
        tick();
        seq_start = 0;
        tick();
        chk("rs_fb_field", {30'd0, seq_field}, 32'd2);
        clr = 0;
        #1;
        chk("rs_busy",  {31'd0, seq_busy}, 32'd0);
        chk("rs_field", {30'd0, seq_field}, 32'd0);
        chk("rs_done",  {31'd0, seq_done}, 32'd0);
        chk("rs_rout",  {16'd0, r_out}, 32'h0);
        chk("rs_cse",   c_sign_extend, 32'h0);
        tick();
        clr = 1;
        tick();
        chk("rs_after_done", {31'd0, seq_done}, 32'd0);
        chk("rs_after_busy", {31'd0, seq_busy}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sel_encode_seq.md
# sel_encode_seq

Parametrised select-and-encode unit for the datapath register file. It latches the instruction word locally and decodes the Ra, Rb and Rc fields into one-hot register-file in/out enables. It also sign-extends the C immediate. A built-in operand sequencer can also step through the selected register fields on its own, one field per cycle, so the control unit can issue a multi-operand read with a single start pulse.

## Interface
Parameters:
- DATA_W, 32: instruction and immediate width.
- NREG, 16: number of registers; power of two, 2..32. RSEL_W = clog2(NREG) is a derived local parameter.
- RA_LSB, 23: LSB of the Ra field; the field is RSEL_W bits wide.
- RB_LSB, 19: LSB of the Rb field.
- RC_LSB, 15: LSB of the Rc field.
- IMM_W, 19: width of the C immediate, taken from IR[IMM_W-1:0].

Ports:
- clk  in  1  clock; rising edge active.
- clr  in  1  asynchronous, active-low reset.
- ir_ld  in  1  load ir_in into the local IR.
- ir_in  in  DATA_W  instruction from the bus.
- gra, grb, grc  in  1 each  manual field selects.
- rin, rout, baout  in  1 each  manual register write enable, read enable, and base-address read.
- seq_start  in  1  start an operand sequence.
- seq_mask  in  3  fields to sequence: bit0 Ra, bit1 Rb, bit2 Rc.
- r_in  out  NREG  one-hot register write enables.
- r_out  out  NREG  one-hot register read enables.
- sel_idx  out  RSEL_W  currently decoded register index.
- r0_zero  out  1  base-address read of R0; the bus must drive 0.
- c_sign_extend  out  DATA_W  sign-extended C immediate.
- seq_busy  out  1  sequencer not idle.
- seq_field  out  2  field being sequenced: 0 none, 1 Ra, 2 Rb, 3 Rc.
- seq_done  out  1  one-cycle completion pulse.

## Operation
- Local IR
  - Loaded on a clk edge when ir_ld=1 and seq_busy=0.
  - ir_ld is ignored while seq_busy=1.
  - Cleared to 0 by reset.
- Manual mode (seq_busy=0)
  - sel_idx = (Ra & {gra}) | (Rb & {grb}) | (Rc & {grc}), taken from the local IR.
  - Multiple selects are OR-combined; this is legacy behaviour and is intentional.
  - r_in = decode(sel_idx) & {rin}.
  - r_out = decode(sel_idx) & {rout | baout}.
  - r0_zero = baout & (sel_idx == 0) & (gra | grb | grc).
  - All of these outputs are combinational.
- c_sign_extend = {(DATA_W-IMM_W){IR[IMM_W-1]}, IR[IMM_W-1:0]}.
  - Combinational from the local IR and always valid.
- Sequencer states: IDLE, FA, FB, FC, DONE.
- Transitions:
  - IDLE → first set field of seq_mask (order Ra, Rb, Rc) on seq_start=1.
  - If seq_mask=000, IDLE → DONE.
  - The mask is latched on the start edge.
  - Each field state → next set field of the latched mask; after the last set field → DONE.
  - DONE → IDLE unconditionally.
- In FA/FB/FC:
  - sel_idx = that field of the local IR.
  - r_out = decode(sel_idx).
  - r_in = 0.
  - r0_zero = 0.
  - seq_field = 1/2/3 respectively.
  - gr*, rin, rout and baout are ignored.
- In DONE:
  - seq_done = 1.
  - r_out = 0, r_in = 0.
  - seq_field = 0.
- seq_busy = (state != IDLE).
- seq_start is ignored when state != IDLE.

## Timing
- Reset (clr=0, asynchronous):
  - State goes to IDLE; latched mask and IR go to 0.
  - seq_busy=0, seq_done=0, seq_field=0, c_sign_extend=0.
  - r_in, r_out, sel_idx and r0_zero follow the manual inputs against IR=0.
- IR load has 1-cycle latency: the decode reflects the new IR in the cycle after the ir_ld edge.
- Sequence latency, with seq_start sampled at edge k:
  - The first field is driven during cycle k..k+1.
  - Each further set field adds one cycle.
  - seq_done is high for one cycle after the last field.
  - seq_busy falls one edge later.
  - mask=111: fields at edges k, k+1, k+2; DONE after edge k+3; IDLE after edge k+4.
  - mask=000: DONE after edge k; IDLE after edge k+1.
- Simultaneous ir_ld and seq_start in IDLE:
  - Both take effect on the same edge.
  - The sequence decodes the newly loaded IR.
- Reset asserted mid-sequence aborts it immediately. No seq_done pulse is issued.
- seq_start held high continuously: a new sequence starts on the first edge in IDLE, i.e. the edge after DONE.

## Test plan
- Manual decode: load IR=0x0B1A0000 (Ra=6, Rb=3, Rc=4), gra=1, rout=1 → r_out=0x0040, r_in=0. Then grb=1, rin=1 alone → r_in=0x0008.
- BAout on R0: load IR with Ra=0, gra=1, baout=1 → r_out=0x0001, r0_zero=1. With Ra=5 → r0_zero=0.
- Sign extension: IR[18:0]=0x40001 → c_sign_extend=0xFFFC0001. IR[18:0]=0x3FFFF → 0x0003FFFF.
- Full sequence: Ra=6/Rb=3/Rc=4, start with mask=111 → r_out 0x0040, 0x0008, 0x0010 on three consecutive cycles with seq_field 1, 2, 3. Then seq_done for exactly 1 cycle, then seq_busy=0. Manual rin=1 during the sequence → r_in stays 0.
- Sparse and empty masks: mask=101 → two field cycles (Ra then Rc) then done. mask=000 → seq_done on the cycle after start, r_out=0 throughout. ir_ld while busy → IR unchanged.
- Reset mid-sequence: clr=0 during the FB cycle → immediate IDLE, seq_busy=0, no seq_done. Rerun with NREG=8, RA_LSB=24 and check 8-bit one-hot decoding.
